alu_input_loader: RTL and testbench
===================================

# alu_input_loader

Operand/opcode capture front end for the TP1 ALU board design. Takes the raw board switches and push-buttons, synchronises and debounces the buttons, and on each debounced press latches the switch value into operand A, operand B or the opcode register. Sits between the board I/O pins and the ALU. The ALU result goes back out to the LEDs.

## Interface

- `NB_DATA`, 8, operand width and switch count.
- `NB_OP`, 6, opcode width; taken from `i_sw[NB_OP-1:0]`; must satisfy `NB_OP <= NB_DATA`.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a button level change; must be >= 1.
- `NB_DEBOUNCE`, 20, debounce counter width; must satisfy `2^NB_DEBOUNCE > DEBOUNCE_CYCLES`.

Ports:

- `clk`  in  1  system clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to `clk`.
- `i_sw`  in  `NB_DATA`  raw switches, asynchronous to `clk`.
- `i_button`  in  3  raw push-buttons, active-high, asynchronous. [0] loads A, [1] loads B, [2] loads opcode.
- `o_data_a`  out  `NB_DATA`  operand A register.
- `o_data_b`  out  `NB_DATA`  operand B register.
- `o_op`  out  `NB_OP`  opcode register.
- `o_loaded`  out  3  sticky flags, one per register: bit k = register k has been loaded since reset.
- `o_ready`  out  1  `&o_loaded`; all three registers have been loaded at least once.
- `o_upd`  out  1  one-cycle pulse, registered; high the cycle after any register load.

## Operation

- **Synchronisers:** `i_sw` and `i_button` each pass through a 2-FF synchroniser. Internal logic uses only the synchronised values.
- **Debounce:** one independent debouncer per button, with a stable level `stb[k]` and counter `cnt[k]`.
  - If `sync[k] == stb[k]`, `cnt[k] <= 0`.
  - Else if `cnt[k] == DEBOUNCE_CYCLES-1`, then `stb[k] <= sync[k]` and `cnt[k] <= 0`.
  - Else `cnt[k] <= cnt[k]+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` differing cycles restarts the count and changes nothing.
- **Edge detect:** `stb_d[k]` is `stb[k]` delayed one cycle. `press[k] = stb[k] & ~stb_d[k]`, a one-cycle pulse per accepted press. Release edges take no action. A held button produces exactly one press.
- **Load:** on the edge where `press[k]` is high, the selected register takes the synchronised switches and `o_loaded[k]` sets.
  - k=0: `o_data_a <= sw_sync`
  - k=1: `o_data_b <= sw_sync`
  - k=2: `o_op <= sw_sync[NB_OP-1:0]`
- **Update pulse:** `o_upd` is asserted on the same edge as any load and lasts one cycle.
- **Simultaneous presses:** each register loads independently in the same cycle from the same `sw_sync` value, and `o_upd` pulses once.
- **Reload:** pressing again overwrites the register; `o_loaded` stays set.
- **Sticky flags:** `o_loaded` clears only on reset.
- **Reset values:** all outputs 0; all synchroniser, `stb`, `stb_d` and `cnt` state 0.
- **Reset mid-operation:** all state returns to reset values immediately, including mid-debounce counts and loaded registers.
- **Button held across reset release:** it is seen as a fresh 0→1 change and loads once after the normal latency.

## Timing

- **Press latency:** `i_button[k]` rises before edge 0 and is held.
  - `sync[k]` = 1 after edge 2.
  - `stb[k]` = 1 after edge `DEBOUNCE_CYCLES+2`.
  - Register loads and `o_upd` = 1 after edge `DEBOUNCE_CYCLES+3`.
  - `o_upd` = 0 after edge `DEBOUNCE_CYCLES+4`.
- **Switch sampling:** the loaded value is `i_sw` as sampled two edges before the load edge. Switches must be stable for 3 cycles before the load edge.
- **Release latency:** `DEBOUNCE_CYCLES+2` edges until `stb` returns to 0. A new press can be accepted only after that.
- **Minimum press spacing:** about `2*DEBOUNCE_CYCLES+4` cycles per accepted press.
- **No combinational paths:** no input-to-output paths; all outputs are registered except `o_ready`, which is the AND of registered bits.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES=4`, `NB_DATA=8`, `NB_OP=6`.

1. **Reset:** assert `i_rst_n`=0 mid-run → all outputs 0 immediately. Release with buttons at 0 → outputs stay 0.
2. **Single load:** `i_sw`=8'hA5, raise `i_button[0]` before edge 0 and hold 20 cycles.
   - → `o_data_a`=8'hA5 and `o_upd`=1 after edge 7 only.
   - → `o_loaded`=3'b001.
   - → no second load while held.
3. **Glitch rejection:** `i_button[1]` high for 3 cycles, then low → `o_data_b` stays 0, `o_upd` never pulses. Then a 4-cycle-synced press loads normally.
4. **Full load:** load A=8'h12, B=8'h34, then op with `i_sw`=8'hE7.
   - → `o_op`=6'h27.
   - → `o_ready` rises on the op load edge.
5. **Simultaneous presses:** `i_sw`=8'h5A, raise buttons [0] and [2] in the same cycle.
   - → after edge 7: `o_data_a`=8'h5A, `o_op`=6'h1A.
   - → a single `o_upd` pulse.
6. **Reset mid-debounce, then reload:**
   - Reset at cycle 5 of a press → no load occurs.
   - Button still held after release → loads at edge 7 after release.
   - Reload A with 8'hFF after a release → `o_data_a`=8'hFF, `o_loaded[0]` stays 1.

Source files
------------

// File: rtl/alu_input_loader.sv
// Board front end for the ALU: synchronises switches and buttons, debounces buttons, and on
// each accepted press latches the switches into operand A, operand B or the opcode register.
module alu_input_loader #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_OP           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NB_DEBOUNCE     = 20
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [2:0]         i_button,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [2:0]         o_loaded,
  output logic               o_ready,
  output logic               o_upd
);

  localparam logic [NB_DEBOUNCE-1:0] CntMax = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

  logic [NB_DATA-1:0]     sw_meta_q, sw_sync_q;
  logic [2:0]             btn_meta_q, btn_sync_q;
  logic [2:0]             stb_q, stb_dly_q, stb_next;
  logic [NB_DEBOUNCE-1:0] cnt_q    [3];
  logic [NB_DEBOUNCE-1:0] cnt_next [3];
  logic [2:0]             press;
  logic [NB_DATA-1:0]     data_a_q, data_b_q;
  logic [NB_OP-1:0]       op_q;
  logic [2:0]             loaded_q;
  logic                   upd_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= i_sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= i_button;
      btn_sync_q <= btn_meta_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      stb_next[k] = stb_q[k];
      cnt_next[k] = '0;
      if (btn_sync_q[k] != stb_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          stb_next[k] = btn_sync_q[k];
        end else begin
          cnt_next[k] = cnt_q[k] + NB_DEBOUNCE'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stb_q     <= '0;
      stb_dly_q <= '0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      stb_q     <= stb_next;
      stb_dly_q <= stb_q;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_next[k];
      end
    end
  end

  assign press = stb_q & ~stb_dly_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      loaded_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      if (press[0]) data_a_q <= sw_sync_q;
      if (press[1]) data_b_q <= sw_sync_q;
      if (press[2]) op_q     <= sw_sync_q[NB_OP-1:0];
      loaded_q <= loaded_q | press;
      upd_q    <= |press;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_op     = op_q;
  assign o_loaded = loaded_q;
  assign o_ready  = &loaded_q;
  assign o_upd    = upd_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader: vector table, hand-written timing sequences and random stimulus
// checked every cycle against a sample-history reference model.
module tb_alu_input_loader;

  localparam int DC      = 4;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NB_DATA-1:0] sw;
  logic [2:0]         btn;
  logic [NB_DATA-1:0] data_a, data_b;
  logic [NB_OP-1:0]   op;
  logic [2:0]         loaded;
  logic               ready, upd;

  int checks = 0;
  int errors = 0;

  alu_input_loader #(
    .NB_DATA        (NB_DATA),
    .NB_OP          (NB_OP),
    .DEBOUNCE_CYCLES(DC),
    .NB_DEBOUNCE    (20)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_sw    (sw),
    .i_button(btn),
    .o_data_a(data_a),
    .o_data_b(data_b),
    .o_op    (op),
    .o_loaded(loaded),
    .o_ready (ready),
    .o_upd   (upd)
  );

  always #5 clk = ~clk;

  // Reference model: history of input samples taken at each clock edge.
  bit [2:0] mb_q[$];
  bit [7:0] ms_q[$];
  bit [2:0] m_stb, m_stb_prev, m_loaded;
  bit [7:0] m_a, m_b;
  bit [5:0] m_op;
  bit       m_upd;

  function automatic void model_reset();
    mb_q.delete();
    ms_q.delete();
    for (int i = 0; i < DC + 3; i++) begin
      mb_q.push_back(3'b000);
      ms_q.push_back(8'h00);
    end
    m_stb = '0; m_stb_prev = '0; m_loaded = '0;
    m_a = '0; m_b = '0; m_op = '0; m_upd = 1'b0;
  endfunction

  // Called once per clock edge with the inputs that edge sampled.
  function automatic void model_step(input bit [2:0] b, input bit [7:0] s);
    int       sz;
    bit [2:0] press, nstb;
    bit [7:0] sw_late;
    bit       flip;
    mb_q.push_back(b);
    ms_q.push_back(s);
    sz      = mb_q.size();
    sw_late = ms_q[sz-3];
    press   = m_stb & ~m_stb_prev;
    if (press[0]) m_a = sw_late;
    if (press[1]) m_b = sw_late;
    if (press[2]) m_op = sw_late[5:0];
    m_loaded = m_loaded | press;
    m_upd    = |press;
    nstb = m_stb;
    for (int k = 0; k < 3; k++) begin
      flip = 1'b1;
      for (int j = 0; j < DC; j++) begin
        if (mb_q[sz-3-j][k] == m_stb[k]) flip = 1'b0;
      end
      if (flip) nstb[k] = ~m_stb[k];
    end
    m_stb_prev = m_stb;
    m_stb      = nstb;
    while (mb_q.size() > 2 * DC + 8) begin
      void'(mb_q.pop_front());
      void'(ms_q.pop_front());
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("model_data_a", 32'(data_a), 32'(m_a));
    chk("model_data_b", 32'(data_b), 32'(m_b));
    chk("model_op", 32'(op), 32'(m_op));
    chk("model_loaded", 32'(loaded), 32'(m_loaded));
    chk("model_ready", 32'(ready), 32'(&m_loaded));
    chk("model_upd", 32'(upd), 32'(m_upd));
  endtask

  task automatic cycle(input logic [2:0] b, input logic [7:0] s);
    btn = b;
    sw  = s;
    @(posedge clk);
    model_step(b, s);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_data_a", 32'(data_a), 32'h0);
    chk("rst_data_b", 32'(data_b), 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_loaded", 32'(loaded), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [7:0] sw;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;
    logic [2:0] exp_loaded;
    logic       exp_ready;
  } rec_t;

  task automatic press_rec(input rec_t r, input int idx);
    int upds = 0;
    for (int n = 1; n <= 8; n++) begin
      cycle(r.btn, r.sw);
      if (upd) upds++;
      if (n == 6) chk($sformatf("rec%0d_upd_early", idx), 32'(upd), 32'h0);
      if (n == 7) chk($sformatf("rec%0d_ready_at_load", idx), 32'(ready), 32'(r.exp_ready));
    end
    for (int n = 0; n < 12; n++) begin
      cycle(3'b000, r.sw);
      if (upd) upds++;
    end
    chk($sformatf("rec%0d_upd_pulses", idx), 32'(upds), 32'd1);
    chk($sformatf("rec%0d_data_a", idx), 32'(data_a), 32'(r.exp_a));
    chk($sformatf("rec%0d_data_b", idx), 32'(data_b), 32'(r.exp_b));
    chk($sformatf("rec%0d_op", idx), 32'(op), 32'(r.exp_op));
    chk($sformatf("rec%0d_loaded", idx), 32'(loaded), 32'(r.exp_loaded));
    chk($sformatf("rec%0d_ready", idx), 32'(ready), 32'(r.exp_ready));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl[5];
    logic [2:0] rb;
    logic [7:0] rs;
    tbl[0] = '{btn: 3'b001, sw: 8'h12, exp_a: 8'h12, exp_b: 8'h00, exp_op: 6'h00,
               exp_loaded: 3'b001, exp_ready: 1'b0};
    tbl[1] = '{btn: 3'b010, sw: 8'h34, exp_a: 8'h12, exp_b: 8'h34, exp_op: 6'h00,
               exp_loaded: 3'b011, exp_ready: 1'b0};
    tbl[2] = '{btn: 3'b100, sw: 8'hE7, exp_a: 8'h12, exp_b: 8'h34, exp_op: 6'h27,
               exp_loaded: 3'b111, exp_ready: 1'b1};
    tbl[3] = '{btn: 3'b101, sw: 8'h5A, exp_a: 8'h5A, exp_b: 8'h34, exp_op: 6'h1A,
               exp_loaded: 3'b111, exp_ready: 1'b1};
    tbl[4] = '{btn: 3'b001, sw: 8'hFF, exp_a: 8'hFF, exp_b: 8'h34, exp_op: 6'h1A,
               exp_loaded: 3'b111, exp_ready: 1'b1};

    // Power-on reset, then idle with buttons low.
    rst_n = 1'b0;
    btn   = '0;
    sw    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_data_a", 32'(data_a), 32'h0);
    chk("por_loaded", 32'(loaded), 32'h0);
    chk("por_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) cycle(3'b000, 8'h00);
    chk("idle_upd", 32'(upd), 32'h0);
    chk("idle_loaded", 32'(loaded), 32'h0);

    // Single load of A with exact latency, held long enough to prove one press only.
    for (int n = 1; n <= 20; n++) begin
      cycle(3'b001, 8'hA5);
      chk($sformatf("single_upd_e%0d", n), 32'(upd), 32'(n == 7));
      chk($sformatf("single_a_e%0d", n), 32'(data_a), (n >= 7) ? 32'hA5 : 32'h0);
    end
    chk("single_loaded", 32'(loaded), 32'b001);
    for (int n = 0; n < 12; n++) cycle(3'b000, 8'hA5);

    // Reset with a loaded register clears it immediately.
    do_reset(2);

    // Three-cycle glitch on button 1 is rejected.
    for (int n = 0; n < 3; n++) cycle(3'b010, 8'h3C);
    for (int n = 0; n < 12; n++) begin
      cycle(3'b000, 8'h3C);
      chk("glitch_upd", 32'(upd), 32'h0);
      chk("glitch_b", 32'(data_b), 32'h0);
    end
    // Four-cycle press is just long enough.
    for (int n = 1; n <= 12; n++) begin
      cycle((n <= 4) ? 3'b010 : 3'b000, 8'h3C);
      chk($sformatf("short_upd_e%0d", n), 32'(upd), 32'(n == 7));
    end
    chk("short_b", 32'(data_b), 32'h3C);
    chk("short_loaded", 32'(loaded), 32'b010);
    for (int n = 0; n < 10; n++) cycle(3'b000, 8'h3C);

    // Reset during debounce; button still held afterwards loads after the normal latency.
    for (int n = 1; n <= 5; n++) cycle(3'b001, 8'hC3);
    do_reset(3);
    for (int n = 1; n <= 10; n++) begin
      cycle(3'b001, 8'hC3);
      chk($sformatf("held_upd_e%0d", n), 32'(upd), 32'(n == 7));
      chk($sformatf("held_a_e%0d", n), 32'(data_a), (n >= 7) ? 32'hC3 : 32'h0);
    end
    chk("held_loaded", 32'(loaded), 32'b001);
    for (int n = 0; n < 12; n++) cycle(3'b000, 8'hC3);

    for (int i = 0; i < 5; i++) press_rec(tbl[i], i);

    // Random buttons and switches with occasional resets.
    rb = '0;
    rs = '0;
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 5) == 0) rb = 3'($urandom);
      if ($urandom_range(0, 2) == 0) rs = 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset(2);
      cycle(rb, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
